// File: rtl/als_pkg.sv
// Shared types and defaults for the ambient-light sensor SPI responder.
// Holds the state enum, default frame geometry and the frame-word builder.
package als_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } als_state_e;

  localparam int ALS_DATA_WIDTH = 8;
  localparam int ALS_LEAD_ZEROS = 3;
  localparam int ALS_FRAME_BITS = 16;

  localparam int ALS_TAIL_ZEROS =
    ALS_FRAME_BITS - ALS_LEAD_ZEROS - ALS_DATA_WIDTH;

  // {lead zeros, sample, tail zeros} at the default geometry
  function automatic logic [ALS_FRAME_BITS-1:0] als_frame_word(
    input logic [ALS_DATA_WIDTH-1:0] s
  );
    logic [ALS_FRAME_BITS-1:0] w;
    w = '0;
    w[ALS_TAIL_ZEROS +: ALS_DATA_WIDTH] = s;
    return w;
  endfunction

endpackage

// File: rtl/als_responder_sync_edge.sv
// Multi-stage synchronizer with edge detect for the ALS responder.
// Outputs the synchronized level plus one-cycle rise and fall strobes.
module als_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/als_responder.sv
// SPI responder emulating the ambient-light sensor for loop-back builds.
// Ports: clk, reset (async, active-low), sample/sample_valid (fabric load),
// ALS_CS/ALS_SCK in, ALS_SDO out, busy, bit_count, frame_done, frame_abort.
// Define ALS_RESPONDER_TRISTATE_EN to float ALS_SDO while CS is high.
module als_responder
  import als_pkg::*;
#(
  parameter int DATA_WIDTH  = ALS_DATA_WIDTH,
  parameter int LEAD_ZEROS  = ALS_LEAD_ZEROS,
  parameter int FRAME_BITS  = ALS_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  sample_valid,
  input  logic                  ALS_CS,
  input  logic                  ALS_SCK,
  output logic                  ALS_SDO,
  output logic                  busy,
  output logic [4:0]            bit_count,
  output logic                  frame_done,
  output logic                  frame_abort
);

  localparam int         TAIL = FRAME_BITS - LEAD_ZEROS - DATA_WIDTH;
  localparam logic [4:0] LAST = 5'(FRAME_BITS);

  logic cs_lvl, cs_rise, cs_fall;
  logic sck_lvl, sck_rise, sck_fall;
  logic unused_sck;

  als_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ALS_CS),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  als_sync_edge #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sck_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ALS_SCK),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  assign unused_sck = sck_lvl ^ sck_rise;

  als_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  sdo_q, sdo_d;
  logic                  busy_q, busy_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic [FRAME_BITS-1:0] word;

  always_comb begin
    word = '0;
    word[TAIL +: DATA_WIDTH] = hold_q;
  end

  always_comb begin
    state_d = state_q;
    hold_d  = sample_valid ? sample : hold_q;
    shreg_d = shreg_q;
    sdo_d   = sdo_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    abort_d = 1'b0;
    // CS rise wins over any SCK edge seen in the same cycle
    if (cs_rise) begin
      state_d = IDLE;
      done_d  = (state_q == DONE);
      abort_d = (state_q == SHIFT);
      sdo_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            // frame built from the pre-update holding value
            state_d = SHIFT;
            shreg_d = word;
            sdo_d   = word[FRAME_BITS-1];
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
        SHIFT: begin
          if (sck_fall && !cs_lvl) begin
            shreg_d = shreg_q << 1;
            sdo_d   = shreg_d[FRAME_BITS-1];
            cnt_d   = cnt_q + 5'd1;
            if (cnt_d == LAST) begin
              state_d = DONE;
              sdo_d   = 1'b0;
            end
          end
        end
        DONE: sdo_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      shreg_q <= '0;
      sdo_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shreg_q <= shreg_d;
      sdo_q   <= sdo_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end

`ifdef ALS_RESPONDER_TRISTATE_EN
  assign ALS_SDO = cs_lvl ? 1'bz : sdo_q;
`else
  assign ALS_SDO = sdo_q;
`endif

  assign busy        = busy_q;
  assign bit_count   = cnt_q;
  assign frame_done  = done_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_als_responder.sv
// Scoreboarded bench for als_responder: a master drives CS/SCK, a monitor
// matches frame_done/frame_abort pulses and captured words to a queue.
module tb_als_responder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sample = '0;
  logic       sample_valid = 1'b0;
  logic       ALS_CS = 1'b1;
  logic       ALS_SCK = 1'b0;
  wire        ALS_SDO;
  logic       busy;
  logic [4:0] bit_count;
  logic       frame_done;
  logic       frame_abort;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] word;
    logic        is_done;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] cap;

`ifdef ALS_RESPONDER_TRISTATE_EN
  localparam logic IDLE_SDO = 1'bz;
`else
  localparam logic IDLE_SDO = 1'b0;
`endif

  als_responder dut (
    .clk          (clk),
    .reset        (reset),
    .sample       (sample),
    .sample_valid (sample_valid),
    .ALS_CS       (ALS_CS),
    .ALS_SCK      (ALS_SCK),
    .ALS_SDO      (ALS_SDO),
    .busy         (busy),
    .bit_count    (bit_count),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every pulse must match the next expected frame
  always @(negedge clk) begin
    if (reset && (frame_done || frame_abort)) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pulse: unexpected done=%b abort=%b",
                 frame_done, frame_abort);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (frame_done !== e.is_done || frame_abort !== !e.is_done) begin
          fails++;
          $display("FAIL kind: done=%b abort=%b, want done=%b",
                   frame_done, frame_abort, e.is_done);
        end else if (e.is_done && cap !== e.word) begin
          fails++;
          $display("FAIL word: got %h, want %h", cap, e.word);
        end
      end
    end
  end

  task automatic load(input logic [7:0] v);
    @(negedge clk);
    sample = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // CS low, optional sample load in the CS-fall detection cycle, then clocks
  task automatic frame(input int nfall, input int extra,
                       input bit sv_en, input logic [7:0] sv_val);
    cap = '0;
    @(negedge clk);
    ALS_CS = 1'b0;
    repeat (2) @(negedge clk);
    if (sv_en) begin
      sample = sv_val;
      sample_valid = 1'b1;
    end
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nfall + extra; i++) begin
      ALS_SCK = 1'b1;
      if (i < nfall) cap = {cap[14:0], ALS_SDO};
      repeat (4) @(negedge clk);
      ALS_SCK = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic cs_high();
    ALS_CS = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [15:0] w, input logic d);
    exp_t e;
    e.word = w;
    e.is_done = d;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sdo", {15'd0, ALS_SDO}, {15'd0, IDLE_SDO});
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_cnt", {11'd0, bit_count}, 16'd0);
    check("rst_pulses", {14'd0, frame_done, frame_abort}, 16'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 frame
    load(8'hA5);
    exp_q.push_back(mk(16'h14A0, 1'b1));
    frame(16, 0, 1'b0, 8'h00);
    check("done_busy", {15'd0, busy}, 16'd1);
    check("done_cnt", {11'd0, bit_count}, 16'd16);
    check("done_sdo", {15'd0, ALS_SDO}, 16'd0);
    cs_high();
    check("idle_busy", {15'd0, busy}, 16'd0);

    // back-to-back 0x00 then 0xFF
    load(8'h00);
    exp_q.push_back(mk(16'h0000, 1'b1));
    frame(16, 0, 1'b0, 8'h00);
    cs_high();
    load(8'hFF);
    exp_q.push_back(mk(16'h1FE0, 1'b1));
    frame(16, 0, 1'b0, 8'h00);
    cs_high();

    // abort after 7 falls
    exp_q.push_back(mk(16'h0000, 1'b0));
    frame(7, 0, 1'b0, 8'h00);
    check("mid_cnt", {11'd0, bit_count}, 16'd7);
    cs_high();
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_sdo", {15'd0, ALS_SDO}, {15'd0, IDLE_SDO});

    // load collides with CS-fall detection
    load(8'h81);
    exp_q.push_back(mk(16'h1020, 1'b1));
    frame(16, 0, 1'b1, 8'h3C);
    cs_high();
    exp_q.push_back(mk(16'h0780, 1'b1));
    frame(16, 0, 1'b0, 8'h00);
    cs_high();

    // extra SCK edges after the last bit
    load(8'hFF);
    exp_q.push_back(mk(16'h1FE0, 1'b1));
    frame(16, 3, 1'b0, 8'h00);
    check("extra_sdo", {15'd0, ALS_SDO}, 16'd0);
    check("extra_cnt", {11'd0, bit_count}, 16'd16);
    cs_high();
    check("extra_idle_sdo", {15'd0, ALS_SDO}, {15'd0, IDLE_SDO});

    // reset mid-SHIFT: no pulse may reach the monitor
    load(8'hFF);
    frame(5, 0, 1'b0, 8'h00);
    check("pre_rst_busy", {15'd0, busy}, 16'd1);
    reset = 1'b0;
    #1;
    check("mrst_sdo", {15'd0, ALS_SDO}, {15'd0, IDLE_SDO});
    check("mrst_busy", {15'd0, busy}, 16'd0);
    check("mrst_cnt", {11'd0, bit_count}, 16'd0);
    ALS_CS = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_busy", {15'd0, busy}, 16'd0);

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
